gpio_io_ctrl: RTL

GPIO_IO_CTRL -- requirements
Module: gpio_io_ctrl

---
 rtl/gpio_pkg.sv | 20 ++
 rtl/gpio_sync_edge.sv | 37 +++
 rtl/gpio_io_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Shared types and constants for the GPIO I/O controller.
package gpio_pkg;

  localparam int unsigned NPINS_DEF = 34;
  localparam int unsigned TURN_DEF  = 2;
  localparam int unsigned CNT_W     = 4;

  localparam logic [1:0] ADDR_DIR       = 2'd0;
  localparam logic [1:0] ADDR_OUT       = 2'd1;
  localparam logic [1:0] ADDR_EDGE_EN   = 2'd2;
  localparam logic [1:0] ADDR_EDGE_STAT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_APPLY   = 2'd3
  } gpio_state_e;

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop input synchronizer plus a history flop for rising-edge detection.
module gpio_sync_edge #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         gated_reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise_c
);

  logic [W-1:0] sync1_q, sync1_d;
  logic [W-1:0] sync2_q, sync2_d;
  logic [W-1:0] prev_q,  prev_d;

  // Next-state for the synchronizer chain and history flop.
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Chain registers; reset to 0 so a pin high through reset reports one edge.
  always_ff @(posedge clk or negedge gated_reset) begin
    if (!gated_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rise_c = sync2_q & ~prev_q;

endmodule

// File: rtl/gpio_io_ctrl.sv
// GPIO controller: register file, edge status/irq and glitch-free direction changes.
module gpio_io_ctrl
  import gpio_pkg::*;
#(
  parameter int unsigned NPINS = NPINS_DEF,
  parameter int unsigned TURN  = TURN_DEF
) (
  input  logic             clk,
  input  logic             gated_reset,
  input  logic             wr_en,
  input  logic [1:0]       addr,
  input  logic [NPINS-1:0] wr_data,
  output logic [NPINS-1:0] rd_data,
  output logic             busy,
  input  logic [NPINS-1:0] gpio_in,
  output logic [NPINS-1:0] gpio_out,
  output logic [NPINS-1:0] gpio_oeb,
  output logic             irq
);

  gpio_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NPINS-1:0] dir_active_q, dir_active_d;
  logic [NPINS-1:0] dir_pend_q, dir_pend_d;
  logic [NPINS-1:0] out_q, out_d;
  logic [NPINS-1:0] edge_en_q, edge_en_d;
  logic [NPINS-1:0] edge_stat_q, edge_stat_d;
  logic             irq_q, irq_d;
  logic             busy_q, busy_d;
  logic [NPINS-1:0] stat_clr;
  logic [NPINS-1:0] rise_c;

  gpio_sync_edge #(.W(NPINS)) u_sync_edge (
    .clk         (clk),
    .gated_reset (gated_reset),
    .din         (gpio_in),
    .rise_c      (rise_c)
  );

  // Register writes, direction-change sequencing and edge status update.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dir_active_d = dir_active_q;
    dir_pend_d   = dir_pend_q;
    out_d        = out_q;
    edge_en_d    = edge_en_q;
    stat_clr     = '0;

    if (wr_en) begin
      case (addr)
        ADDR_OUT:       out_d     = wr_data;
        ADDR_EDGE_EN:   edge_en_d = wr_data;
        ADDR_EDGE_STAT: stat_clr  = wr_data;
        default:        ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (wr_en && (addr == ADDR_DIR)) begin
          dir_pend_d = wr_data;
          state_d    = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Pins leaving output mode let go before anything turns on.
        dir_active_d = dir_active_q & dir_pend_q;
        cnt_d        = CNT_W'(TURN - 1);
        state_d      = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_APPLY;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_APPLY: begin
        dir_active_d = dir_pend_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A fresh edge overrides a same-cycle clear.
    edge_stat_d = (edge_stat_q & ~stat_clr) | rise_c;
    irq_d       = |(edge_stat_q & edge_en_q);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and register flops.
  always_ff @(posedge clk or negedge gated_reset) begin
    if (!gated_reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      dir_active_q <= '0;
      dir_pend_q   <= '0;
      out_q        <= '0;
      edge_en_q    <= '0;
      edge_stat_q  <= '0;
      irq_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dir_active_q <= dir_active_d;
      dir_pend_q   <= dir_pend_d;
      out_q        <= out_d;
      edge_en_q    <= edge_en_d;
      edge_stat_q  <= edge_stat_d;
      irq_q        <= irq_d;
      busy_q       <= busy_d;
    end
  end

  // Register read mux; DIR shows the pending value while a change is running.
  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_DIR:       rd_data = busy_q ? dir_pend_q : dir_active_q;
      ADDR_OUT:       rd_data = out_q;
      ADDR_EDGE_EN:   rd_data = edge_en_q;
      ADDR_EDGE_STAT: rd_data = edge_stat_q;
      default:        rd_data = '0;
    endcase
  end

  assign busy     = busy_q;
  assign irq      = irq_q;
  assign gpio_out = out_q;
  assign gpio_oeb = ~dir_active_q;

endmodule
